general_pipe_reg: RTL and testbench
===================================

# general_pipe_reg

Parametrised elastic pipeline register: a chain of DEPTH `general_dff`-style stages with per-stage valid bits, valid/ready backpressure, bubble collapsing and synchronous flush. It replaces hand-chained load-enabled registers on PIM datapaths where the downstream consumer (accumulator, write-back port) can stall. With DEPTH=1 and out_ready tied high, it reduces to a load-enabled register with a valid bit.

## Interface
- DATA_WIDTH, 32, payload width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- OCC_W, $clog2(DEPTH+1), width of occupancy (derived, not overridden)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low, clears all stages
- flush  input  1  synchronous clear of all stage valid bits
- in_valid  input  1  upstream has a word on in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_WIDTH  payload in
- out_valid  output  1  stage DEPTH-1 holds a valid word
- out_ready  input  1  downstream takes out_data this cycle
- out_data  output  DATA_WIDTH  payload out, driven directly from the stage DEPTH-1 register
- occupancy  output  OCC_W  number of valid stages, 0..DEPTH

## Operation
- Per stage i: registers valid_q[i] and data_q[i]. Stage 0 is fed from in_*; stage DEPTH-1 drives out_*.
- Advance chain, combinational:
  - adv[DEPTH-1] = ~valid_q[DEPTH-1] | out_ready
  - adv[i] = ~valid_q[i] | adv[i+1]
  - in_ready = adv[0] & ~flush
- On each edge with no flush, every stage i with adv[i]=1:
  - valid_q[i] <= upstream valid (in_valid for i=0, valid_q[i-1] otherwise)
  - data_q[i] <= upstream data, only when upstream valid is 1; otherwise data_q[i] holds
- Stages with adv[i]=0 hold both registers.
- Bubble collapsing: an empty stage always advances, so gaps close while the output is stalled. Full capacity is DEPTH words.
- Transfers: input handshake is in_valid & in_ready; output handshake is out_valid & out_ready. Words leave in acceptance order, with no loss or duplication.
- flush=1: out_valid and in_ready forced to 0 that cycle, so no transfers occur. All valid_q clear on the next edge; data_q hold.
- occupancy = popcount(valid_q); it reflects register state only.
- Reset (rst_n low, asynchronous):
  - all valid_q=0 and all data_q=0
  - therefore out_valid=0, out_data=0, occupancy=0
  - in_ready=1 after reset, if flush=0
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Latency, unstalled: a word accepted at edge k shows out_valid=1 in the cycle after edge k+DEPTH-1. That is DEPTH cycles after the acceptance cycle; for DEPTH=1, the next cycle.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready depends combinationally on out_ready and flush, through DEPTH OR stages. out_valid, out_data and occupancy are register-only, except that out_valid is gated by flush.
- Full with out_ready=1: simultaneous accept and drain in the same cycle; occupancy unchanged.
- Full with out_ready=0: in_ready=0, and all stages hold.
- Empty: out_valid=0. out_ready is ignored.
- flush together with in_valid: the input word is dropped; in_ready was 0.
- flush together with rst_n low: reset dominates.

## Structure
- Shared package `pim_pipe_pkg`: function clog2_occ(depth), plus the legal-parameter check (DEPTH>=1, DATA_WIDTH>=1) as an elaboration-time assertion.
- Sub-module `pipe_stage`: one valid+data stage.
  - Ports: clk, rst_n, flush, adv, up_valid, up_data, valid_q, data_q.
  - Instantiated DEPTH times under a generate loop.
- Advance chain and popcount live in the top module.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 words held (DEPTH=4) -> out_valid=0, out_data=0, occupancy=0 without a clock edge; in_ready=1 after release.
- Streaming: DEPTH=4, DATA_WIDTH=32, out_ready=1; push 0x1..0x8 on consecutive cycles -> 0x1 appears 4 cycles after acceptance, then one word per cycle in order; occupancy steady at 4.
- Stall and collapse:
  - push 0xA, then one idle cycle, then 0xB, with out_ready=0 -> both collapse toward the output; occupancy=2.
  - push 0xC, 0xD -> occupancy=4 and in_ready=0 on the fifth push attempt.
  - release out_ready -> output order A, B, C, D.
- Full simultaneous: DEPTH=2 full, out_ready=1 and in_valid=1 every cycle for 10 cycles -> 10 accepts and 10 drains; occupancy stays 2; no drops.
- Flush: occupancy=3, flush=1 for one cycle with in_valid=1 (data 0x55) -> in_ready=0 and out_valid=0 that cycle; occupancy=0 next cycle; 0x55 never appears at the output.
- DEPTH=1 degenerate: alternate out_ready 0/1 under continuous in_valid -> one word accepted per drain; out_data changes only after an output handshake.

Source files
------------

// File: rtl/pim_pipe_pkg.sv
// Shared helpers for PIM datapath pipeline blocks: occupancy sizing and
// parameter legality, evaluated at elaboration.
package pim_pipe_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int clog2_occ(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic bit pipe_params_legal(input int depth, input int data_width);
        return (depth >= 1) && (data_width >= 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a payload register that only
// loads when a valid word arrives, so the last payload lingers after drain.
module pipe_stage
    import pim_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  adv,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  valid_q,
    output logic [DATA_WIDTH-1:0] data_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (adv) begin
            valid_q <= up_valid;
            if (up_valid) data_q <= up_data;
        end
    end

endmodule

// File: rtl/general_pipe_reg.sv
// Elastic pipeline register: DEPTH valid+data stages with valid/ready
// backpressure, bubble collapsing and synchronous flush.
module general_pipe_reg
    import pim_pipe_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int OCC_W      = clog2_occ(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]      occupancy
);

    if (!pipe_params_legal(DEPTH, DATA_WIDTH)) begin : g_param_check
        $error("general_pipe_reg: DEPTH and DATA_WIDTH must both be >= 1");
    end

    logic [DEPTH-1:0]                 valid_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]                 up_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] up_data;
    logic [DEPTH-1:0]                 adv;
    logic [OCC_W-1:0]                 occ_sum;

    // A stage may advance if it is empty or anything downstream of it can move;
    // carried as a running OR from the output end back to stage 0.
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run    = run | ~valid_q[i];
            adv[i] = run;
        end
    end

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_sum = occ_sum + OCC_W'(valid_q[i]);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_valid[i] = in_valid;
            assign up_data[i]  = in_data;
        end else begin : g_body
            assign up_valid[i] = valid_q[i-1];
            assign up_data[i]  = data_q[i-1];
        end

        pipe_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .adv     (adv[i]),
            .up_valid(up_valid[i]),
            .up_data (up_data[i]),
            .valid_q (valid_q[i]),
            .data_q  (data_q[i])
        );
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_sum;

endmodule

// File: tb/tb_general_pipe_reg.sv
// Directed bench for general_pipe_reg at DEPTH 4, 2 and 1 with hand-computed
// expectations; inputs change 1ns after the rising edge.
module tb_general_pipe_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // DEPTH=4 instance
    logic        d4_flush, d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
    logic [31:0] d4_in_data, d4_out_data;
    logic [2:0]  d4_occ;
    // DEPTH=2 instance
    logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [31:0] d2_in_data, d2_out_data;
    logic [1:0]  d2_occ;
    // DEPTH=1 instance
    logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [31:0] d1_in_data, d1_out_data;
    logic [0:0]  d1_occ;

    general_pipe_reg #(.DATA_WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .flush(d4_flush),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
        .occupancy(d4_occ)
    );

    general_pipe_reg #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(d2_flush),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
        .occupancy(d2_occ)
    );

    general_pipe_reg #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
        .occupancy(d1_occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {d4_flush, d4_in_valid, d4_out_ready} = '0; d4_in_data = '0;
        {d2_flush, d2_in_valid, d2_out_ready} = '0; d2_in_data = '0;
        {d1_flush, d1_in_valid, d1_out_ready} = '0; d1_in_data = '0;

        // ---- reset state
        #3;
        chk("rst_out_valid", 32'(d4_out_valid), 32'd0);
        chk("rst_out_data",  d4_out_data,       32'd0);
        chk("rst_occ",       32'(d4_occ),       32'd0);
        chk("rst_in_ready",  32'(d4_in_ready),  32'd1);
        chk("rst_d1_occ",    32'(d1_occ),       32'd0);
        #10 rst_n = 1'b1;
        tick();

        // ---- streaming 1..8, out_ready high: word w shows after edge w+3
        d4_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            int acc, drn;
            d4_in_valid = (c < 8);
            d4_in_data  = 32'(c + 1);
            #1;
            chk("stream_in_ready", 32'(d4_in_ready), 32'd1);
            tick();
            acc = (c + 1 < 8) ? c + 1 : 8;
            drn = (c - 3 < 0) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
            chk("stream_out_valid", 32'(d4_out_valid), (c >= 3 && c <= 10) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 10) chk("stream_out_data", d4_out_data, 32'(c - 2));
            chk("stream_occ", 32'(d4_occ), 32'(acc - drn));
        end
        d4_in_valid = 1'b0;

        // ---- stall and collapse
        d4_out_ready = 1'b0;
        d4_in_valid = 1'b1; d4_in_data = 32'hA; tick();
        d4_in_valid = 1'b0;                     tick();
        d4_in_valid = 1'b1; d4_in_data = 32'hB; tick();
        d4_in_valid = 1'b0;
        tick(); tick(); tick();
        chk("stall_occ2",      32'(d4_occ),       32'd2);
        chk("stall_out_valid", 32'(d4_out_valid), 32'd1);
        chk("stall_out_A",     d4_out_data,       32'hA);
        chk("stall_in_ready",  32'(d4_in_ready),  32'd1);
        d4_in_valid = 1'b1; d4_in_data = 32'hC; tick();
        d4_in_data = 32'hD; tick();
        chk("stall_occ4", 32'(d4_occ), 32'd4);
        d4_in_data = 32'hE; #1;
        chk("stall_full_in_ready", 32'(d4_in_ready), 32'd0);
        tick();
        chk("stall_full_hold_occ", 32'(d4_occ),  32'd4);
        chk("stall_full_hold_A",   d4_out_data,  32'hA);
        d4_in_valid = 1'b0;
        d4_out_ready = 1'b1; #1;
        chk("drain_A", d4_out_data, 32'hA);
        tick(); chk("drain_B", d4_out_data, 32'hB);
        tick(); chk("drain_C", d4_out_data, 32'hC);
        tick(); chk("drain_D", d4_out_data, 32'hD);
        chk("drain_D_valid", 32'(d4_out_valid), 32'd1);
        tick();
        chk("drain_empty_valid", 32'(d4_out_valid), 32'd0);
        chk("drain_empty_occ",   32'(d4_occ),       32'd0);

        // ---- flush with three words held and a competing input word
        d4_out_ready = 1'b0;
        d4_in_valid = 1'b1; d4_in_data = 32'h11; tick();
        d4_in_data = 32'h22; tick();
        d4_in_data = 32'h33; tick();
        d4_in_valid = 1'b0; tick();
        chk("flush_pre_occ",   32'(d4_occ),       32'd3);
        chk("flush_pre_valid", 32'(d4_out_valid), 32'd1);
        d4_flush = 1'b1; d4_in_valid = 1'b1; d4_in_data = 32'h55; d4_out_ready = 1'b1; #1;
        chk("flush_in_ready",  32'(d4_in_ready),  32'd0);
        chk("flush_out_valid", 32'(d4_out_valid), 32'd0);
        tick();
        d4_flush = 1'b0; d4_in_valid = 1'b0; #1;
        chk("flush_post_occ", 32'(d4_occ), 32'd0);
        for (int c = 0; c < 6; c++) begin
            chk("flush_no_55", 32'(d4_out_valid), 32'd0);
            tick();
        end

        // ---- DEPTH=2 full with simultaneous accept and drain
        d2_out_ready = 1'b0;
        d2_in_valid = 1'b1; d2_in_data = 32'h100; tick();
        d2_in_data = 32'h101; tick();
        chk("d2_full_occ",      32'(d2_occ),      32'd2);
        chk("d2_full_in_ready", 32'(d2_in_ready), 32'd0);
        d2_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            d2_in_data = 32'h102 + 32'(c);
            #1;
            chk("d2_sim_in_ready",  32'(d2_in_ready),  32'd1);
            chk("d2_sim_out_valid", 32'(d2_out_valid), 32'd1);
            chk("d2_sim_out_data",  d2_out_data,       32'h100 + 32'(c));
            tick();
            chk("d2_sim_occ", 32'(d2_occ), 32'd2);
        end
        d2_in_valid = 1'b0;
        chk("d2_tail0", d2_out_data, 32'h10A);
        tick();
        chk("d2_tail1", d2_out_data, 32'h10B);
        tick();
        chk("d2_empty", 32'(d2_out_valid), 32'd0);

        // ---- DEPTH=1 with alternating out_ready
        d1_out_ready = 1'b0;
        d1_in_valid = 1'b1; d1_in_data = 32'h200; tick();
        for (int i = 0; i < 6; i++) begin
            d1_out_ready = i[0];
            d1_in_data   = 32'h201 + 32'(i / 2);
            #1;
            chk("d1_in_ready",  32'(d1_in_ready),  32'(i % 2));
            chk("d1_out_valid", 32'(d1_out_valid), 32'd1);
            tick();
            chk("d1_out_data", d1_out_data, 32'h200 + 32'((i + 1) / 2));
        end
        d1_in_valid = 1'b0; d1_out_ready = 1'b1;
        tick();
        chk("d1_drained", 32'(d1_occ), 32'd0);

        // ---- asynchronous reset mid-stream with three words held
        d4_out_ready = 1'b0;
        d4_in_valid = 1'b1; d4_in_data = 32'h71; tick();
        d4_in_data = 32'h72; tick();
        d4_in_data = 32'h73; tick();
        d4_in_valid = 1'b0; tick();
        chk("mid_pre_occ",  32'(d4_occ),      32'd3);
        chk("mid_pre_data", d4_out_data,      32'h71);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(d4_out_valid), 32'd0);
        chk("mid_rst_out_data",  d4_out_data,       32'd0);
        chk("mid_rst_occ",       32'(d4_occ),       32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(d4_in_ready), 32'd1);
        tick();
        chk("mid_rel_occ", 32'(d4_occ), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
